// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: edge-detected word capture, show-ahead read,
// sticky overrun, fill-threshold and receive-timeout interrupts.
module uart_rx_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 704
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    rx_tick,
  input  logic                    rx_done,
  input  logic [DATA_WIDTH-1:0]   rx_data_in,
  input  logic                    rx_error_in,
  input  logic                    rd_en,
  input  logic [$clog2(DEPTH):0]  threshold,
  input  logic                    ovr_clr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_error,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overrun,
  output logic                    thr_irq,
  output logic                    timeout_irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNTING,
    EXPIRED
  } tstate_t;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [CW-1:0]       count_nx;
  logic [TW-1:0]       tcnt;
  logic                done_q;
  logic                push;
  logic                pop;
  logic                wr;
  logic                lost;
  tstate_t             state;

  assign push  = rx_done & ~done_q;
  assign pop   = rd_en & ~empty;
  // a pop in the same cycle frees the slot the push needs
  assign wr    = push & (~full | pop);
  assign lost  = push & full & ~pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign thr_irq  = (threshold != '0) && (count >= threshold);
  assign rd_data  = mem[rptr][DATA_WIDTH-1:0];
  assign rd_error = mem[rptr][DATA_WIDTH];

  always_comb begin
    count_nx = count;
    unique case (1'b1)
      wr & ~pop: count_nx = count + CW'(1);
      pop & ~wr: count_nx = count - CW'(1);
      default:   ;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      done_q  <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      done_q <= rx_done;
      if (wr)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      count <= count_nx;
      if (lost)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (wr && !PRESET)
      mem[wptr] <= {rx_error_in, rx_data_in};
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      tcnt        <= '0;
      timeout_irq <= 1'b0;
    end else if (count_nx == '0) begin
      state       <= IDLE;
      tcnt        <= '0;
      timeout_irq <= 1'b0;
    end else if (push || pop) begin
      state       <= COUNTING;
      tcnt        <= '0;
      timeout_irq <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state       <= COUNTING;
          tcnt        <= '0;
          timeout_irq <= 1'b0;
        end
        COUNTING: begin
          if (rx_tick) begin
            if (tcnt == TW'(TIMEOUT_TICKS - 1)) begin
              state       <= EXPIRED;
              timeout_irq <= 1'b1;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        EXPIRED: timeout_irq <= 1'b1;
        default: begin
          state       <= IDLE;
          timeout_irq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int T     = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          rx_tick;
  logic          rx_done;
  logic [DW-1:0] rx_data_in;
  logic          rx_error_in;
  logic          rd_en;
  logic [CW-1:0] threshold;
  logic          ovr_clr;
  logic [DW-1:0] rd_data;
  logic          rd_error;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overrun;
  logic          thr_irq;
  logic          timeout_irq;

  int ntest = 0;
  int nfail = 0;

  logic [DW:0] q[$];
  bit          m_ovr;
  bit          m_exp;
  bit          m_prev;
  int          m_ticks;

  uart_rx_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .TIMEOUT_TICKS(T)
  ) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .rx_tick(rx_tick),
    .rx_done(rx_done),
    .rx_data_in(rx_data_in),
    .rx_error_in(rx_error_in),
    .rd_en(rd_en),
    .threshold(threshold),
    .ovr_clr(ovr_clr),
    .rd_data(rd_data),
    .rd_error(rd_error),
    .empty(empty),
    .full(full),
    .count(count),
    .overrun(overrun),
    .thr_irq(thr_irq),
    .timeout_irq(timeout_irq)
  );

  always #5 PCLK = ~PCLK;

  // model: a word queue, sticky overrun, and "ticks since last activity"
  task automatic step();
    bit push, pop, lost;
    if (PRESET) begin
      q.delete();
      m_ovr = 0; m_prev = 0; m_ticks = 0; m_exp = 0;
    end else begin
      push = rx_done && !m_prev;
      m_prev = rx_done;
      pop = rd_en && q.size() != 0;
      lost = push && q.size() == DEPTH && !pop;
      if (pop) void'(q.pop_front());
      if (push && !lost) q.push_back({rx_error_in, rx_data_in});
      m_ovr = lost || (m_ovr && !ovr_clr);
      if (q.size() == 0 || push || pop) begin
        m_ticks = 0; m_exp = 0;
      end else if (rx_tick && !m_exp) begin
        m_ticks++;
        m_exp = (m_ticks == T);
      end
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle_inputs();
    PRESET = 0; rx_tick = 0; rx_done = 0; rx_data_in = '0;
    rx_error_in = 0; rd_en = 0; ovr_clr = 0; threshold = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    PRESET = 1;
    step();
    PRESET = 0;
  endtask

  task automatic send(input logic [DW-1:0] d, input int len);
    rx_done = 1; rx_data_in = d; rx_error_in = 0;
    repeat (len) step();
    rx_done = 0;
    step();
  endtask

  task automatic pop_one();
    rd_en = 1;
    step();
    rd_en = 0;
  endtask

  task automatic test_reset();
    do_reset();
    threshold = 1;
    #1;
    ntest++;
    if ({empty, full, overrun, thr_irq, timeout_irq} !== 5'b10000) begin
      nfail++;
      $display("FAIL reset_flags: got %b want 10000",
               {empty, full, overrun, thr_irq, timeout_irq});
    end
    ntest++;
    if (count !== 0) begin
      nfail++; $display("FAIL reset_count: got %0d want 0", count);
    end
  endtask

  task automatic test_three_words();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 8'hA5; exp_d[1] = 8'h3C; exp_d[2] = 8'h7E;
    do_reset();
    for (int i = 0; i < 3; i++) send(exp_d[i], 5);
    ntest++;
    if (count !== 3) begin
      nfail++; $display("FAIL three_count: got %0d want 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      ntest++;
      if ({rd_error, rd_data} !== {1'b0, exp_d[i]}) begin
        nfail++;
        $display("FAIL three_pop%0d: got %b/%h want 0/%h",
                 i, rd_error, rd_data, exp_d[i]);
      end
      pop_one();
    end
    ntest++;
    if (empty !== 1'b1) begin
      nfail++; $display("FAIL three_empty: got %b want 1", empty);
    end
  endtask

  task automatic test_overrun_and_full_pushpop();
    do_reset();
    for (int i = 0; i <= DEPTH; i++) send(DW'(8'h10 + i), 1);
    ntest++;
    if ({full, overrun, count} !== {1'b1, 1'b1, CW'(DEPTH)}) begin
      nfail++;
      $display("FAIL ovr_state: got full=%b ovr=%b cnt=%0d want 1 1 %0d",
               full, overrun, count, DEPTH);
    end
    ovr_clr = 1;
    step();
    ovr_clr = 0;
    ntest++;
    if (overrun !== 1'b0) begin
      nfail++; $display("FAIL ovr_clr: got %b want 0", overrun);
    end
    rx_done = 1; rx_data_in = 8'hEE; rd_en = 1;
    step();
    rx_done = 0; rd_en = 0;
    ntest++;
    if ({count, overrun} !== {CW'(DEPTH), 1'b0}) begin
      nfail++;
      $display("FAIL full_pushpop: got cnt=%0d ovr=%b want %0d 0",
               count, overrun, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] e;
      e = (i == DEPTH - 1) ? DW'(8'hEE) : DW'(8'h11 + i);
      ntest++;
      if (rd_data !== e) begin
        nfail++; $display("FAIL drain%0d: got %h want %h", i, rd_data, e);
      end
      pop_one();
    end
    ntest++;
    if (empty !== 1'b1) begin
      nfail++; $display("FAIL drain_empty: got %b want 1", empty);
    end
    pop_one();
    ntest++;
    if ({empty, count} !== {1'b1, CW'(0)}) begin
      nfail++;
      $display("FAIL underflow: got e=%b cnt=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_threshold();
    do_reset();
    threshold = 4;
    for (int i = 0; i < 3; i++) send(DW'(i), 1);
    ntest++;
    if (thr_irq !== 1'b0) begin
      nfail++; $display("FAIL thr_below: got %b want 0", thr_irq);
    end
    rx_done = 1; rx_data_in = 8'h33;
    step();
    rx_done = 0;
    ntest++;
    if (thr_irq !== 1'b1) begin
      nfail++; $display("FAIL thr_rise: got %b want 1", thr_irq);
    end
    step();
    pop_one();
    ntest++;
    if (thr_irq !== 1'b0) begin
      nfail++; $display("FAIL thr_fall: got %b want 0", thr_irq);
    end
    threshold = 0;
    #1;
    ntest++;
    if (thr_irq !== 1'b0) begin
      nfail++; $display("FAIL thr_zero: got %b want 0", thr_irq);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'h5A, 1);
    for (int k = 1; k <= T; k++) begin
      rx_tick = 1;
      step();
      rx_tick = 0;
      step();
      if (k == T - 1) begin
        ntest++;
        if (timeout_irq !== 1'b0) begin
          nfail++; $display("FAIL tmo_early: got %b want 0", timeout_irq);
        end
      end
    end
    ntest++;
    if (timeout_irq !== 1'b1) begin
      nfail++; $display("FAIL tmo_fire: got %b want 1", timeout_irq);
    end
    pop_one();
    ntest++;
    if ({timeout_irq, empty} !== 2'b01) begin
      nfail++;
      $display("FAIL tmo_pop: got irq=%b e=%b want 0 1", timeout_irq, empty);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 5; i++) send(DW'(8'h40 + i), 1);
    rx_done = 1; rx_data_in = 8'hFF; PRESET = 1;
    step();
    PRESET = 0; rx_done = 0;
    ntest++;
    if ({count, empty, overrun} !== {CW'(0), 1'b1, 1'b0}) begin
      nfail++;
      $display("FAIL mid_reset: got cnt=%0d e=%b ovr=%b want 0 1 0",
               count, empty, overrun);
    end
  endtask

  task automatic test_random();
    bit quiet;
    bit m_thr;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      quiet = ((cyc / 150) % 3) == 2;
      PRESET = ($urandom_range(0, 399) == 0);
      rx_tick = ($urandom_range(0, 3) == 0);
      if (rx_done) rx_done = $urandom_range(0, 1);
      else rx_done = !quiet && ($urandom_range(0, 2) == 0);
      rx_data_in = DW'($urandom);
      rx_error_in = $urandom_range(0, 1);
      rd_en = !quiet && ($urandom_range(0, 3) == 0);
      ovr_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) threshold = CW'($urandom_range(0, 9));
      step();
      m_thr = (threshold != 0) && (q.size() >= int'(threshold));
      ntest++;
      if (count !== CW'(q.size())) begin
        nfail++;
        $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, count, q.size());
      end
      ntest++;
      if ({empty, full, overrun, thr_irq, timeout_irq} !==
          {q.size() == 0, q.size() == DEPTH, m_ovr, m_thr, m_exp}) begin
        nfail++;
        $display("FAIL rnd_flags@%0d: got %b want %b", cyc,
                 {empty, full, overrun, thr_irq, timeout_irq},
                 {q.size() == 0, q.size() == DEPTH, m_ovr, m_thr, m_exp});
      end
      if (q.size() != 0) begin
        ntest++;
        if ({rd_error, rd_data} !== q[0]) begin
          nfail++;
          $display("FAIL rnd_head@%0d: got %h want %h", cyc,
                   {rd_error, rd_data}, q[0]);
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_three_words();
    test_overrun_and_full_pushpop();
    test_threshold();
    test_timeout();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
